dvi_framebuffer_fetch: RTL and testbench

DVI_FRAMEBUFFER_FETCH -- requirements
Module: dvi_framebuffer_fetch

---
 rtl/dvi_framebuffer_fetch.sv | 131 +++++++++++++
 tb/tb_dvi_framebuffer_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_framebuffer_fetch.sv
// Framebuffer fetch: splits each frame into memory read bursts, gated by pixel-FIFO credits.
// Requests appear one cycle after the issue condition and hold until accepted; no burst issues without credits.
module dvi_framebuffer_fetch #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 1023
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        frame_start_i,
  input  logic [31:0] frame_base_i,
  input  logic [23:0] frame_words_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [7:0]  mem_len_o,
  input  logic        mem_accept_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i,
  output logic        fifo_push_o,
  output logic [31:0] fifo_data_o,
  input  logic        fifo_pop_i,
  output logic        busy_o,
  output logic        frame_late_o
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, FETCH} state_t;

  localparam logic [8:0]  BURST_MAX = 9'(BURST_LEN);
  localparam logic [10:0] CRED_MAX  = 11'(FIFO_DEPTH);

  state_t      state;
  logic [31:0] addr;
  logic [23:0] remaining;
  logic [10:0] credits;
  logic [11:0] outstanding;
  logic        restart_pend;
  logic [31:0] pend_base;
  logic [23:0] pend_words;

  logic        accept;
  logic        req_hold;
  logic [8:0]  burst_n;
  logic [8:0]  acc_n;
  logic [11:0] credits_sum;
  logic [10:0] credits_nxt;

  assign accept   = mem_req_o & mem_accept_i;
  assign req_hold = mem_req_o & ~mem_accept_i;
  assign burst_n  = (remaining >= {15'd0, BURST_MAX}) ? BURST_MAX : remaining[8:0];
  assign acc_n    = accept ? ({1'b0, mem_len_o} + 9'd1) : 9'd0;

  // Returned pops and accepted bursts net out in one cycle; pops past a full FIFO are clipped.
  assign credits_sum = {1'b0, credits} + {11'd0, fifo_pop_i} - {3'd0, acc_n};
  assign credits_nxt = (credits_sum > {1'b0, CRED_MAX}) ? CRED_MAX : credits_sum[10:0];

  assign fifo_push_o = mem_valid_i;
  assign fifo_data_o = mem_data_i;
  assign busy_o      = (state == FETCH) || (outstanding != 12'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      addr         <= 32'd0;
      remaining    <= 24'd0;
      credits      <= CRED_MAX;
      outstanding  <= 12'd0;
      restart_pend <= 1'b0;
      pend_base    <= 32'd0;
      pend_words   <= 24'd0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= 32'd0;
      mem_len_o    <= 8'd0;
      frame_late_o <= 1'b0;
    end else begin
      credits     <= credits_nxt;
      outstanding <= outstanding + {3'd0, acc_n} - {11'd0, mem_valid_i};

      if (!enable_i) begin
        frame_late_o <= 1'b0;
        // A request already on the bus must be seen through before shutting down.
        if (!req_hold) begin
          state        <= IDLE;
          mem_req_o    <= 1'b0;
          restart_pend <= 1'b0;
        end
      end else begin
        if (accept) mem_req_o <= 1'b0;

        case (state)
          IDLE: state <= WAIT_FRAME;

          WAIT_FRAME, FETCH: begin
            if (frame_start_i) begin
              if (state == FETCH && remaining != 24'd0) frame_late_o <= 1'b1;
              if (req_hold) begin
                restart_pend <= 1'b1;
                pend_base    <= frame_base_i;
                pend_words   <= frame_words_i;
              end else begin
                restart_pend <= 1'b0;
                addr         <= frame_base_i;
                remaining    <= frame_words_i;
                state        <= (frame_words_i != 24'd0) ? FETCH : WAIT_FRAME;
              end
            end else if (accept) begin
              if (restart_pend) begin
                // The old burst only consumed credits; the new frame starts from scratch.
                restart_pend <= 1'b0;
                addr         <= pend_base;
                remaining    <= pend_words;
                state        <= (pend_words != 24'd0) ? FETCH : WAIT_FRAME;
              end else begin
                addr      <= addr + 32'({acc_n, 2'b00});
                remaining <= remaining - {15'd0, acc_n};
                if (remaining == {15'd0, acc_n}) state <= WAIT_FRAME;
              end
            end else if (state == FETCH && !mem_req_o && remaining != 24'd0 &&
                         credits >= {2'b00, burst_n}) begin
              mem_req_o  <= 1'b1;
              mem_addr_o <= addr;
              mem_len_o  <= 8'(burst_n - 9'd1);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dvi_framebuffer_fetch.sv
// Bench for dvi_framebuffer_fetch: random memory/FIFO behaviour against a burst-list and credit-ledger model.
module tb_dvi_framebuffer_fetch;

  localparam int BURST = 16;
  localparam int DEPTH = 1023;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  l;
  } burst_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        frame_start_i = 1'b0;
  logic [31:0] frame_base_i = 32'd0;
  logic [23:0] frame_words_i = 24'd0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_len_o;
  logic        mem_accept_i = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_data_i = 32'd0;
  logic        fifo_push_o;
  logic [31:0] fifo_data_o;
  logic        fifo_pop_i = 1'b0;
  logic        busy_o;
  logic        frame_late_o;

  dvi_framebuffer_fetch #(.BURST_LEN(BURST), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
    .frame_start_i(frame_start_i), .frame_base_i(frame_base_i), .frame_words_i(frame_words_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_len_o(mem_len_o),
    .mem_accept_i(mem_accept_i), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i),
    .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o), .fifo_pop_i(fifo_pop_i),
    .busy_o(busy_o), .frame_late_o(frame_late_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_chk = 0;
  int          n_pass = 0;
  burst_t      exp_q[$];
  logic [31:0] beat_q[$];
  int          credits_m = DEPTH;
  int          fifo_cnt = 0;
  int          acc_cnt = 0;
  bit          acc_mode = 1'b0;
  bit          acc_force = 1'b0;
  bit          pop_mode = 1'b1;
  bit          pop_force = 1'b0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [7:0]  prev_len = 8'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  // Expected burst list of a frame: consecutive BURST-word chunks, last one partial.
  task automatic push_frame(input logic [31:0] base, input int words);
    burst_t b;
    for (int off = 0; off < words; off += BURST) begin
      b.a = base + 32'(4 * off);
      b.l = 8'(((words - off < BURST) ? words - off : BURST) - 1);
      exp_q.push_back(b);
    end
  endtask

  // mode 0: fresh frame, 1: restart behind the pending burst, 2: expected to be ignored
  task automatic start_frame(input logic [31:0] base, input int words, input int mode);
    frame_base_i  = base;
    frame_words_i = 24'(words);
    frame_start_i = 1'b1;
    if (mode == 1) while (exp_q.size() > 1) void'(exp_q.pop_back());
    if (mode != 2) push_frame(base, words);
    tick();
    frame_start_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (i < 6000 && !(credits_m == DEPTH && beat_q.size() == 0)) begin
      tick();
      i++;
    end
    check({tag, "_drained"}, 64'(credits_m == DEPTH && beat_q.size() == 0), 1);
  endtask

  task automatic wait_req(input string tag, input int bound);
    for (int i = 0; i < bound && !mem_req_o; i++) tick();
    check(tag, mem_req_o, 1);
  endtask

  // Memory, FIFO consumer and model ledger. Drive at the falling edge, then observe what the next rising edge will sample.
  always @(negedge clk_i) begin : mon
    burst_t e;
    int     n;
    mem_accept_i = acc_mode ? ($urandom_range(0, 3) != 0) : acc_force;
    fifo_pop_i   = (fifo_cnt > 0) && (pop_mode ? ($urandom_range(0, 1) == 1) : pop_force);
    if (beat_q.size() != 0 && $urandom_range(0, 3) != 0) begin
      mem_valid_i = 1'b1;
      mem_data_i  = beat_q.pop_front();
    end else begin
      mem_valid_i = 1'b0;
      mem_data_i  = $urandom;
    end
    #1;
    check("push_strobe", fifo_push_o, mem_valid_i);
    if (mem_valid_i) check("push_data", fifo_data_o, mem_data_i);
    check("credits", dut.credits, credits_m);
    if (prev_hold) begin
      check("hold_req", mem_req_o, 1);
      check("hold_addr", mem_addr_o, prev_addr);
      check("hold_len", mem_len_o, prev_len);
    end
    if (rst_i) begin
      credits_m = DEPTH;
      fifo_cnt  = 0;
      beat_q.delete();
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (mem_valid_i) fifo_cnt++;
      if (fifo_pop_i) fifo_cnt--;
      if (mem_valid_i) check("fifo_room", 64'(fifo_cnt <= DEPTH), 1);
      if (mem_req_o && mem_accept_i) begin
        n = int'(mem_len_o) + 1;
        acc_cnt++;
        check("burst_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("burst_addr", mem_addr_o, e.a);
          check("burst_len", mem_len_o, e.l);
        end
        check("burst_credit", 64'(credits_m >= n), 1);
        credits_m -= n;
        for (int i = 0; i < n; i++) beat_q.push_back($urandom);
      end else begin
        n = 0;
      end
      if (fifo_pop_i) credits_m++;
      if (credits_m > DEPTH) credits_m = DEPTH;
      prev_hold = mem_req_o && !mem_accept_i;
      prev_addr = mem_addr_o;
      prev_len  = mem_len_o;
    end
  end

  initial begin
    int          a0;
    int          c0;
    logic [31:0] ha;
    logic [7:0]  hl;
    logic [31:0] b;
    int          w;

    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst_req", mem_req_o, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_len", mem_len_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_late", frame_late_o, 0);
    check("rst_credits", dut.credits, DEPTH);

    // 40-word frame, memory always accepting
    enable_i  = 1'b1;
    acc_force = 1'b1;
    tick();
    a0 = acc_cnt;
    start_frame(32'h0000_1000, 40, 0);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check("f40_left", exp_q.size(), 0);
    repeat (10) tick();
    check("f40_bursts", acc_cnt - a0, 3);
    wait_idle("f40");
    check("f40_busy", busy_o, 0);

    // No consumer: credits stop the fetch after 63 bursts
    pop_mode  = 1'b0;
    pop_force = 1'b0;
    a0 = acc_cnt;
    start_frame(32'h0000_2000, 2048, 0);
    repeat (400) tick();
    check("nopop_bursts", acc_cnt - a0, 63);
    check("nopop_req", mem_req_o, 0);
    check("nopop_credits", dut.credits, 15);
    pop_force = 1'b1;
    repeat (16) tick();
    pop_force = 1'b0;
    repeat (30) tick();
    check("pop16_bursts", acc_cnt - a0, 64);

    // Accept and pop in the same cycle
    acc_force = 1'b0;
    pop_force = 1'b1;
    tick();
    pop_force = 1'b0;
    wait_req("samecyc_req", 10);
    c0 = int'(dut.credits);
    acc_force = 1'b1;
    pop_force = 1'b1;
    tick();
    acc_force = 1'b0;
    pop_force = 1'b0;
    check("samecyc_credits", dut.credits, 64'(c0 - 15));

    // Enable drops while a request waits for accept
    pop_force = 1'b1;
    repeat (15) tick();
    pop_force = 1'b0;
    wait_req("disable_req", 10);
    ha = mem_addr_o;
    hl = mem_len_o;
    enable_i = 1'b0;
    repeat (5) begin
      tick();
      check("disable_hold_req", mem_req_o, 1);
      check("disable_hold_addr", mem_addr_o, ha);
      check("disable_hold_len", mem_len_o, hl);
    end
    acc_force = 1'b1;
    tick();
    acc_force = 1'b0;
    check("disable_req_gone", mem_req_o, 0);
    exp_q.delete();
    pop_mode = 1'b1;
    wait_idle("disable");
    check("disable_busy", busy_o, 0);

    // frame_start while still in IDLE is dropped
    a0 = acc_cnt;
    acc_force = 1'b1;
    enable_i = 1'b1;
    start_frame(32'h0000_3000, 50, 2);
    repeat (10) tick();
    check("idle_start_bursts", acc_cnt - a0, 0);
    check("idle_start_busy", busy_o, 0);

    // Late frame start with 100 words left, old request pending
    acc_force = 1'b0;
    start_frame(32'h0000_4000, 100, 0);
    wait_req("late_req", 10);
    check("late_before", frame_late_o, 0);
    start_frame(32'h0000_8000, 20, 1);
    check("late_set", frame_late_o, 1);
    acc_force = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("late_left", exp_q.size(), 0);
    repeat (5) tick();
    check("late_sticky", frame_late_o, 1);
    enable_i = 1'b0;
    tick();
    check("late_clear", frame_late_o, 0);
    enable_i = 1'b1;
    tick();

    // Random frames with random accept, return and pop timing; first one wraps the address space
    acc_mode = 1'b1;
    for (int f = 0; f < 8; f++) begin
      b = (f == 0) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFFC);
      w = (f == 0) ? 40 : $urandom_range(0, 300);
      start_frame(b, w, 0);
      check("rand_no_late", frame_late_o, 0);
      for (int i = 0; i < 4000 && exp_q.size() != 0; i++) tick();
      check("rand_frame_left", exp_q.size(), 0);
    end

    // Reset in the middle of a pending burst
    acc_mode  = 1'b0;
    acc_force = 1'b0;
    start_frame(32'h0000_0100, 64, 0);
    wait_req("rstmid_req", 200);
    rst_i = 1'b1;
    tick();
    check("rstmid_req_o", mem_req_o, 0);
    check("rstmid_addr", mem_addr_o, 0);
    check("rstmid_len", mem_len_o, 0);
    check("rstmid_busy", busy_o, 0);
    check("rstmid_late", frame_late_o, 0);
    check("rstmid_credits", dut.credits, DEPTH);
    rst_i = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
